// File: rtl/enc_block_ctrl.sv
// Block-level controller for a turbo-style encoder: loads K host bits into the
// interleaver, waits for it, streams K reads to the encoder, then terminates the trellis.
module enc_block_ctrl #(
  parameter int KMIN     = 40,
  parameter int KMAX     = 6144,
  parameter int TAIL_CYC = 3,
  parameter int WAIT_MAX = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        blk_start,
  input  logic [12:0] blk_size,
  input  logic        abort,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        in_ready,
  output logic        il_data_ready,
  output logic        il_bit,
  input  logic        il_valid,
  output logic        enc_rdreq,
  output logic        term_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT   = 3'd2,
    S_ENCODE = 3'd3,
    S_TAIL   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [12:0] KMIN_L    = 13'(KMIN);
  localparam logic [12:0] KMAX_L    = 13'(KMAX);
  localparam logic [12:0] WAIT_LAST = 13'(WAIT_MAX - 1);
  localparam logic [12:0] TAIL_LAST = 13'(TAIL_CYC - 1);

  state_t      cur, nxt;
  logic [12:0] k_q;
  logic [12:0] bit_cnt;   // load beats in LOAD, interleaver reads in ENCODE
  logic [12:0] cyc_cnt;   // elapsed cycles in WAIT and TAIL
  logic        size_ok, start_ok, start_bad, beat, wait_to, enc_last;

  assign size_ok   = (blk_size >= KMIN_L) && (blk_size <= KMAX_L);
  assign start_ok  = (cur == S_IDLE) && blk_start && size_ok;
  assign start_bad = (cur == S_IDLE) && blk_start && !size_ok;
  assign in_ready  = (cur == S_LOAD) && (bit_cnt < k_q);
  assign beat      = in_ready && in_valid;
  assign wait_to   = (cur == S_WAIT) && !il_valid && (cyc_cnt == WAIT_LAST);
  assign enc_last  = (cur == S_ENCODE) && il_valid && (bit_cnt == k_q - 13'd1);

  // NOTE: every variable gets its default before the case so no latch is inferred.
  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE:   if (start_ok) nxt = S_LOAD;
      S_LOAD:   if (beat && (bit_cnt == k_q - 13'd1)) nxt = S_WAIT;
      S_WAIT:   if (il_valid) nxt = S_ENCODE;
                else if (wait_to) nxt = S_IDLE;
      S_ENCODE: if (enc_last) nxt = S_TAIL;
      S_TAIL:   if (cyc_cnt == TAIL_LAST) nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    // Abort overrides everything, including a WAIT timeout landing in the same cycle.
    if (abort && (cur != S_IDLE)) nxt = S_IDLE;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur           <= S_IDLE;
      k_q           <= '0;
      bit_cnt       <= '0;
      cyc_cnt       <= '0;
      il_data_ready <= 1'b0;
      il_bit        <= 1'b0;
      err           <= 1'b0;
    end else begin
      cur           <= nxt;
      il_data_ready <= beat && !abort;
      if (beat) il_bit <= in_bit;
      err           <= start_bad || (wait_to && !abort);
      if (start_ok) k_q <= blk_size;

      // Counters restart on every state change, so each phase counts from zero.
      if (nxt != cur) begin
        bit_cnt <= '0;
        cyc_cnt <= '0;
      end else begin
        unique case (cur)
          S_LOAD:   if (beat) bit_cnt <= bit_cnt + 13'd1;
          S_ENCODE: if (il_valid) bit_cnt <= bit_cnt + 13'd1;
          S_WAIT,
          S_TAIL:   cyc_cnt <= cyc_cnt + 13'd1;
          default: ;
        endcase
      end
    end
  end

  assign enc_rdreq = (cur == S_ENCODE) && il_valid;
  assign term_en   = (cur == S_TAIL);
  assign busy      = (cur != S_IDLE);
  assign done      = (cur == S_DONE) && !abort;
  assign state     = cur;

endmodule

// File: tb/tb_enc_block_ctrl.sv
// Randomized bench for enc_block_ctrl: a driver predicts each block's write stream and
// completion events into queues; an independent monitor pops and compares them.
module tb_enc_block_ctrl;
  localparam int KMIN     = 40;
  localparam int KMAX     = 6144;
  localparam int TAIL_CYC = 3;
  localparam int WAIT_MAX = 1023;

  logic        clk = 1'b0;
  logic        reset;
  logic        blk_start, abort, in_valid, in_bit, il_valid;
  logic [12:0] blk_size;
  logic        in_ready, il_data_ready, il_bit, enc_rdreq, term_en, busy, done, err;
  logic [2:0]  state;

  enc_block_ctrl #(.KMIN(KMIN), .KMAX(KMAX), .TAIL_CYC(TAIL_CYC), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .blk_start(blk_start), .blk_size(blk_size), .abort(abort),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .il_data_ready(il_data_ready),
    .il_bit(il_bit), .il_valid(il_valid), .enc_rdreq(enc_rdreq), .term_en(term_en),
    .busy(busy), .done(done), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { logic b; int cyc; } wr_t;
  typedef enum { EV_DONE, EV_ERR } ev_t;

  wr_t exp_wr[$];
  ev_t exp_ev[$];
  wr_t mon_w;
  ev_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every interleaver write and every done/err pulse must match the next prediction.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (il_data_ready) begin
        if (exp_wr.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          mon_w = exp_wr.pop_front();
          check("write_cycle", cyc, mon_w.cyc);
          check("il_bit", il_bit, mon_w.b);
        end
      end
      if (done || err) begin
        if (exp_ev.size() == 0) check("unexpected_event", {done, err}, 32'd0);
        else begin
          mon_e = exp_ev.pop_front();
          check("event_done", done, mon_e == EV_DONE);
          check("event_err", err, mon_e == EV_ERR);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic err_start(input logic [12:0] size);
    tick(); blk_start = 1'b1; blk_size = size;
    sample(); check("rej_pre_state", state, 0);
    tick(); blk_start = 1'b0; exp_ev.push_back(EV_ERR);
    sample(); check("rej_err", err, 1); check("rej_busy", busy, 0); check("rej_state", state, 0);
    tick();
    sample(); check("rej_err_pulse", err, 0); check("rej_busy2", busy, 0);
  endtask

  task automatic abort_idle();
    tick(); abort = 1'b1;
    sample();
    tick(); abort = 1'b0;
    sample(); check("idle_abort_state", state, 0); check("idle_abort_busy", busy, 0);
  endtask

  // vmode: 0 = always valid, 1 = toggling load / random encode, 2 = random.
  // il_delay >= WAIT_MAX means the interleaver never answers.
  task automatic run_block(input int k, input int vmode, input int il_delay,
                           input int abort_at, input bit abort_wait);
    int  beats, reads, t, guard;
    bit  v;
    tick(); blk_start = 1'b1; blk_size = 13'(k); abort = 1'b0; in_valid = 1'b0; il_valid = 1'b0;
    sample(); check("start_busy", busy, 0); check("start_state", state, 0);
    tick();
    beats = 0; t = 0;
    while (beats < k) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (t % 2 == 0) : 1'($urandom % 2);
      t++;
      blk_start = ($urandom % 16 == 0); blk_size = 13'($urandom);
      in_valid = v; in_bit = 1'($urandom % 2);
      sample();
      check("load_state", state, 1); check("in_ready", in_ready, 1); check("load_busy", busy, 1);
      if (v) begin
        exp_wr.push_back('{in_bit, cyc + 1});
        beats++;
      end
      tick();
    end
    blk_start = 1'b0; in_valid = 1'b0;

    for (int w = 0; w < il_delay && w < WAIT_MAX; w++) begin
      il_valid = 1'b0; abort = abort_wait && (w == WAIT_MAX - 1);
      sample();
      check("wait_state", state, 2); check("wait_in_ready", in_ready, 0); check("wait_rdreq", enc_rdreq, 0);
      tick();
    end
    abort = 1'b0;
    if (il_delay >= WAIT_MAX) begin
      if (!abort_wait) exp_ev.push_back(EV_ERR);
      sample();
      check("timeout_state", state, 0); check("timeout_err", err, !abort_wait);
      check("timeout_busy", busy, 0); check("timeout_done", done, 0);
      return;
    end
    il_valid = 1'b1;
    sample(); check("wait_state", state, 2); check("wait_rdreq", enc_rdreq, 0);
    tick();

    reads = 0; guard = 0;
    while (reads < k) begin
      if (reads == abort_at) begin
        abort = 1'b1; il_valid = 1'b0;
        sample(); check("abort_enc_state", state, 3);
        tick(); abort = 1'b0; il_valid = 1'b1;
        sample();
        check("abort_state", state, 0); check("abort_rdreq", enc_rdreq, 0);
        check("abort_busy", busy, 0); check("abort_done", done, 0); check("abort_err", err, 0);
        il_valid = 1'b0;
        return;
      end
      il_valid = (vmode == 0) ? 1'b1 : 1'($urandom % 2);
      sample();
      check("enc_state", state, 3); check("enc_rdreq", enc_rdreq, il_valid); check("enc_term", term_en, 0);
      if (il_valid) reads++;
      guard++;
      if (guard > 8 * k + 100) begin
        check("encode_budget", 32'd0, 32'd1);
        return;
      end
      tick();
    end
    exp_ev.push_back(EV_DONE);
    il_valid = 1'b1;
    for (int i = 0; i < TAIL_CYC; i++) begin
      sample();
      check("tail_state", state, 4); check("term_en", term_en, 1); check("tail_rdreq", enc_rdreq, 0);
      tick();
    end
    il_valid = 1'b0;
    sample();
    check("done_state", state, 5); check("done", done, 1); check("done_term", term_en, 0); check("done_busy", busy, 1);
  endtask

  task automatic reset_mid_load();
    tick(); blk_start = 1'b1; blk_size = 13'd100;
    sample();
    tick(); blk_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_bit = 1'($urandom % 2);
      sample(); check("rst_load_state", state, 1);
      exp_wr.push_back('{in_bit, cyc + 1});
      tick();
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_state", state, 0); check("arst_busy", busy, 0); check("arst_in_ready", in_ready, 0);
    check("arst_write", il_data_ready, 0); check("arst_il_bit", il_bit, 0); check("arst_err", err, 0);
    check("arst_done", done, 0); check("arst_term", term_en, 0); check("arst_rdreq", enc_rdreq, 0);
    exp_wr.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; blk_start = 1'b0; blk_size = '0; abort = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; il_valid = 1'b0;
    #1;
    check("reset_state", state, 0); check("reset_busy", busy, 0); check("reset_in_ready", in_ready, 0);
    check("reset_write", il_data_ready, 0); check("reset_err", err, 0); check("reset_done", done, 0);
    #20;
    @(posedge clk); #1 reset = 1'b0;

    err_start(13'd39);
    err_start(13'd6145);
    err_start(13'd0);
    abort_idle();
    run_block(KMIN, 0, 5, -1, 1'b0);
    run_block(KMIN, 0, 2, 20, 1'b0);
    run_block(KMIN, 0, 0, -1, 1'b0);
    for (int i = 0; i < 6; i++)
      run_block(KMIN + int'($urandom % 100), 2, int'($urandom % 20), -1, 1'b0);
    run_block(41, 2, WAIT_MAX, -1, 1'b0);
    run_block(50, 2, WAIT_MAX, -1, 1'b1);
    reset_mid_load();
    run_block(KMAX, 1, 3, -1, 1'b0);
    run_block(KMAX, 0, 1, -1, 1'b0);

    repeat (3) tick();
    check("writes_drained", exp_wr.size(), 0);
    check("events_drained", exp_ev.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
